// File: rtl/rect_fill_pkg.sv
// Shared types and default widths for the rectangle fill engine.
package rect_fill_pkg;

    localparam int X_W_DEF     = 10;
    localparam int Y_W_DEF     = 9;
    localparam int COLOR_W_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_scan_ctr.sv
// Column-major x/y scanner: latches sorted bounds on load, steps y then x,
// and flags the final pixel so the counters never wrap.
module rect_scan_ctr #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic           advance,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic [X_W-1:0] x_r;
    logic [X_W-1:0] xmax_r;
    logic [Y_W-1:0] y_r;
    logic [Y_W-1:0] ymin_r;
    logic [Y_W-1:0] ymax_r;
    logic [X_W-1:0] xmin_s;
    logic [X_W-1:0] xmax_s;
    logic [Y_W-1:0] ymin_s;
    logic [Y_W-1:0] ymax_s;
    logic           last_s;

    assign xmin_s = (x0 <= x1) ? x0 : x1;
    assign xmax_s = (x0 <= x1) ? x1 : x0;
    assign ymin_s = (y0 <= y1) ? y0 : y1;
    assign ymax_s = (y0 <= y1) ? y1 : y0;
    assign last_s = (x_r == xmax_r) && (y_r == ymax_r);

    // Position and bound registers; advancing is suppressed on the last pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r    <= {X_W{1'b0}};
            xmax_r <= {X_W{1'b0}};
            y_r    <= {Y_W{1'b0}};
            ymin_r <= {Y_W{1'b0}};
            ymax_r <= {Y_W{1'b0}};
        end else if (load) begin
            x_r    <= xmin_s;
            xmax_r <= xmax_s;
            y_r    <= ymin_s;
            ymin_r <= ymin_s;
            ymax_r <= ymax_s;
        end else if (advance && !last_s) begin
            if (y_r == ymax_r) begin
                y_r <= ymin_r;
                x_r <= x_r + X_W'(1);
            end else begin
                y_r <= y_r + Y_W'(1);
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    assign x    = x_r;
    assign y    = y_r;
    assign last = last_s;

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: streams every pixel of a rectangle with valid/ready.
// Optional abort input is enabled by defining RECT_FILL_ABORT_EN.
module rect_fill
    import rect_fill_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y0,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done
`ifdef RECT_FILL_ABORT_EN
    ,
    input  logic               abort
`endif
);

    state_t             state_r;
    state_t             state_next_s;
    logic               load_s;
    logic               adv_s;
    logic               last_s;
    logic               abort_s;
    logic               pix_valid_r;
    logic               busy_r;
    logic               done_r;
    logic [COLOR_W-1:0] color_r;

`ifdef RECT_FILL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    rect_scan_ctr #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_s),
        .advance (adv_s),
        .x0      (x0),
        .x1      (x1),
        .y0      (y0),
        .y1      (y1),
        .x       (x),
        .y       (y),
        .last    (last_s)
    );

    // Next-state decode; start and abort are only looked at in their own states.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        adv_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = FILL;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (abort_s) begin
                    state_next_s = DONE;
                end else if (pix_ready) begin
                    if (last_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = FILL;
                        adv_s        = 1'b1;
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and output registers, decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            pix_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            color_r     <= {COLOR_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            pix_valid_r <= (state_next_s == FILL);
            busy_r      <= (state_next_s == FILL);
            done_r      <= (state_next_s == DONE);
            color_r     <= load_s ? fill_color : color_r;
        end
    end

    assign pix_valid = pix_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign color     = color_r;

endmodule

// File: tb/tb_rect_fill.sv
// Randomized bench for rect_fill against a queue-based pixel-list model.
module tb_rect_fill;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    logic       fill_color;
    logic       pix_ready;
    logic       pix_valid;
    logic [9:0] x;
    logic [8:0] y;
    logic       color;
    logic       busy;
    logic       done;
`ifdef RECT_FILL_ABORT_EN
    logic       abort;
`endif

    int n_checks;
    int n_pass;

    rect_fill dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .fill_color (fill_color),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .x          (x),
        .y          (y),
        .color      (color),
        .busy       (busy),
        .done       (done)
`ifdef RECT_FILL_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the IDLE negedge after done.
    // mode: 0 ready always, 1 ready toggling, 2 ready random. abort_at < 0 means no abort.
    task automatic run_fill(input int xa, input int xb, input int ya, input int yb,
                            input int c, input int mode, input int abort_at);
        int qx[$];
        int qy[$];
        int cyc;
        int sent;
        int xmn, xmx, ymn, ymx;
        bit aborted;
        xmn = (xa < xb) ? xa : xb;
        xmx = (xa < xb) ? xb : xa;
        ymn = (ya < yb) ? ya : yb;
        ymx = (ya < yb) ? yb : ya;
        for (int xi = xmn; xi <= xmx; xi++) begin
            for (int yi = ymn; yi <= ymx; yi++) begin
                qx.push_back(xi);
                qy.push_back(yi);
            end
        end
        x0 = 10'(xa); x1 = 10'(xb); y0 = 9'(ya); y1 = 9'(yb);
        fill_color = 1'(c);
        start = 1'b1;
        pix_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        sent = 0;
        aborted = 1'b0;
        while (qx.size() > 0 && cyc < 400) begin
            check("fill_valid", 32'(pix_valid), 32'd1);
            check("fill_busy", 32'(busy), 32'd1);
            check("fill_done", 32'(done), 32'd0);
            check("pix_x", 32'(x), 32'(qx[0]));
            check("pix_y", 32'(y), 32'(qy[0]));
            check("pix_color", 32'(color), 32'(c));
            // Perturb inputs and pulse start; none of it may affect the fill.
            x0 = 10'($urandom_range(0, 1023));
            y1 = 9'($urandom_range(0, 511));
            fill_color = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            if (mode == 0) pix_ready = 1'b1;
            else if (mode == 1) pix_ready = ((cyc % 2) == 0);
            else pix_ready = 1'($urandom_range(0, 1));
`ifdef RECT_FILL_ABORT_EN
            if (abort_at >= 0 && sent == abort_at) begin
                abort = 1'b1;
                aborted = 1'b1;
                cyc++;
                @(negedge clk);
                abort = 1'b0;
                break;
            end
`endif
            if (pix_ready) begin
                void'(qx.pop_front());
                void'(qy.pop_front());
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        pix_ready = 1'b0;
        check("fill_finished", 32'(aborted || (qx.size() == 0)), 32'd1);
        check("end_valid", 32'(pix_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd1);
        @(negedge clk);
        check_idle("after_done");
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n = 1'b0;
        start = 1'b0;
        x0 = 10'd0; x1 = 10'd0; y0 = 9'd0; y1 = 9'd0;
        fill_color = 1'b0;
        pix_ready = 1'b0;
`ifdef RECT_FILL_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        check_idle("reset");
        check("reset_x", 32'(x), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_color", 32'(color), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Full 7x5 fill, then back-to-back swapped corners with backpressure.
        run_fill(0, 6, 0, 4, 1, 0, -1);
        run_fill(5, 2, 3, 1, 0, 1, -1);
        // Single pixel and a small block at the all-ones corner.
        run_fill(1023, 1023, 511, 511, 1, 0, -1);
        run_fill(1023, 1020, 508, 511, 1, 2, -1);

        // Reset in the middle of a fill.
        x0 = 10'd0; x1 = 10'd6; y0 = 9'd0; y1 = 9'd4;
        fill_color = 1'b1;
        pix_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_x", 32'(x), 32'd2);
        check("pre_rst_y", 32'(y), 32'd0);
        reset_n = 1'b0;
        #1;
        check_idle("midfill_rst");
        check("midfill_rst_x", 32'(x), 32'd0);
        check("midfill_rst_y", 32'(y), 32'd0);
        check("midfill_rst_color", 32'(color), 32'd0);
        @(negedge clk);
        check_idle("rst_hold");
        reset_n = 1'b1;
        pix_ready = 1'b0;
        // Start on the same negedge as release: first edge after release must take it.
        run_fill(3, 3, 7, 2, 1, 2, -1);

        for (int i = 0; i < 8; i++) begin
            int xa, xb, ya, yb, w, h;
            xa = int'($urandom_range(0, 1023));
            ya = int'($urandom_range(0, 511));
            w  = int'($urandom_range(0, 5));
            h  = int'($urandom_range(0, 5));
            xb = (xa + w <= 1023) ? xa + w : xa - w;
            yb = (ya + h <= 511) ? ya + h : ya - h;
            if ($urandom_range(0, 1) == 1) run_fill(xb, xa, yb, ya, int'($urandom_range(0, 1)), 2, -1);
            else run_fill(xa, xb, ya, yb, int'($urandom_range(0, 1)), 2, -1);
        end

`ifdef RECT_FILL_ABORT_EN
        run_fill(0, 6, 0, 4, 1, 0, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_idle");
        run_fill(2, 0, 1, 0, 0, 1, -1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
